alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 31 +++
 rtl/mul_seq.sv | 77 +++++++
 rtl/alu_mc.sv | 108 ++++++++++
 tb/tb_alu_mc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: widths, opcode codes,
// sequencer states and the per-operation result bundle.
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int OPC_W    = 4;
  localparam int MUL_ITER = 16;
  localparam int CNT_W    = $clog2(MUL_ITER);

  localparam logic [OPC_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd2;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd3;
  localparam logic [OPC_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OPC_W-1:0] OP_NOT   = 4'd5;
  localparam logic [OPC_W-1:0] OP_SHL   = 4'd6;
  localparam logic [OPC_W-1:0] OP_SHR   = 4'd7;
  localparam logic [OPC_W-1:0] OP_MUL   = 4'd8;
  localparam logic [OPC_W-1:0] OP_PASSB = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rslt;
    logic              carry;
  } alu_out_t;

endpackage

// File: rtl/mul_seq.sv
// Iterative 16x16->32 shift-add multiplier. One partial product is
// accumulated per clock; done flags the cycle whose closing edge retires
// the final iteration, with product already holding the finished sum.
module mul_seq
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W-1:0]   mplr;
  logic                last_iter;

  assign last_iter = (state == ST_MUL) && (cnt == CNT_W'(MUL_ITER - 1));
  assign acc_step  = mplr[0] ? (acc + mcand) : acc;
  assign busy      = (state == ST_MUL);
  assign done      = last_iter;
  assign product   = acc_step;

  // Next-state: leave IDLE on start, return after the last iteration
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)     state_nxt = ST_MUL;
      ST_MUL:  if (last_iter) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Iteration counter; wraps to zero on the final iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == ST_MUL) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Datapath: latch operands at acceptance, then shift-add each cycle
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (start) begin
        acc   <= '0;
        mcand <= {{DATA_W{1'b0}}, a};
        mplr  <= b;
      end
    end else begin
      acc   <= acc_step;
      mcand <= {mcand[2*DATA_W-2:0], 1'b0};
      mplr  <= {1'b0, mplr[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top. Single-cycle ops complete on the accepting edge;
// MUL is handed to mul_seq and its product is registered on retirement.
module alu_mc
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_rslt,
  output logic              zero,
  output logic              carry
);

  logic                  mul_busy;
  logic                  mul_done;
  logic [2*DATA_W-1:0]   mul_product;
  logic                  accept;
  logic                  mul_start;
  logic                  op_fire;
  alu_out_t              op_out;
  logic [DATA_W-1:0]     mul_lo;
  logic                  mul_hi_nz;

  // Single-cycle operations; carry carries borrow or the last bit shifted out
  function automatic alu_out_t alu_eval(input logic [OPC_W-1:0]  op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    alu_out_t        o;
    logic [DATA_W:0] wide;
    o    = '0;
    wide = '0;
    case (op)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        o.rslt  = wide[DATA_W-1:0];
        o.carry = wide[DATA_W];
      end
      OP_SUB: begin
        wide    = {1'b0, a} - {1'b0, b};
        o.rslt  = wide[DATA_W-1:0];
        o.carry = wide[DATA_W];
      end
      OP_AND:   o.rslt = a & b;
      OP_OR:    o.rslt = a | b;
      OP_XOR:   o.rslt = a ^ b;
      OP_NOT:   o.rslt = ~a;
      OP_PASSB: o.rslt = b;
      OP_SHL: begin
        wide    = {1'b0, a} << b[3:0];
        o.rslt  = wide[DATA_W-1:0];
        o.carry = wide[DATA_W];
      end
      OP_SHR: begin
        wide    = {a, 1'b0} >> b[3:0];
        o.rslt  = wide[DATA_W:1];
        o.carry = wide[0];
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign accept    = start && !mul_busy;
  assign mul_start = accept && (opcode == OP_MUL);
  assign op_fire   = accept && (opcode != OP_MUL);
  assign op_out    = alu_eval(opcode, opa, opb);
  assign mul_lo    = mul_product[DATA_W-1:0];
  assign mul_hi_nz = |mul_product[2*DATA_W-1:DATA_W];
  assign busy      = mul_busy;

  mul_seq u_mul_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Result/flag register: written only on a completion, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      alu_rslt <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
    end else begin
      done <= op_fire | mul_done;
      if (op_fire) begin
        alu_rslt <= op_out.rslt;
        carry    <= op_out.carry;
        zero     <= (op_out.rslt == '0);
      end else if (mul_done) begin
        alu_rslt <= mul_lo;
        carry    <= mul_hi_nz;
        zero     <= (mul_lo == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results are queued when a start
// is driven and retired against each done pulse, including its cycle.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [15:0] opa = 16'd0;
  logic [15:0] opb = 16'd0;
  logic        busy;
  logic        done;
  logic [15:0] alu_rslt;
  logic        zero;
  logic        carry;

  typedef struct {
    string       tag;
    logic [15:0] rslt;
    logic        carry;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_mc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .opcode   (opcode),
    .opa      (opa),
    .opb      (opb),
    .busy     (busy),
    .done     (done),
    .alu_rslt (alu_rslt),
    .zero     (zero),
    .carry    (carry)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference behaviour written bit-serially, independent of the RTL form
  function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] w;
    logic [15:0] r;
    logic        c;
    w = '0; r = '0; c = 1'b0;
    case (op)
      4'd0: begin w = 32'(a) + 32'(b); r = w[15:0]; c = (w > 32'hFFFF); end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
      end
      4'd7: begin
        r = a;
        for (int i = 0; i < int'(b[3:0]); i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
      end
      4'd8: begin w = 32'(a) * 32'(b); r = w[15:0]; c = (w[31:16] != 16'd0); end
      4'd9: r = b;
      default: begin r = '0; c = 1'b0; end
    endcase
    return {c, r};
  endfunction

  // Monitor: retire the oldest expectation on each done pulse
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        cur = sb.pop_front();
        chk({cur.tag, "_rslt"}, {16'd0, alu_rslt}, {16'd0, cur.rslt});
        chk({cur.tag, "_carry"}, {31'd0, carry}, {31'd0, cur.carry});
        chk({cur.tag, "_zero"}, {31'd0, zero}, {31'd0, (cur.rslt == 16'd0)});
        chk({cur.tag, "_cycle"}, cyc, cur.due);
      end
    end else if (sb.size() != 0 && sb[0].due < cyc) begin
      chk({sb[0].tag, "_missing_done"}, {31'd0, done}, 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit acc, input bit hold);
    logic [16:0] m;
    exp_t        x;
    @(negedge clk);
    start = 1'b1; opcode = op; opa = a; opb = b;
    if (acc) begin
      m = model(op, a, b);
      x.tag = tag; x.rslt = m[15:0]; x.carry = m[16];
      x.due = cyc + ((op == 4'd8) ? 17 : 1);
      sb.push_back(x);
    end
    if (!hold) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rslt"}, {16'd0, alu_rslt}, 32'd0);
    chk({tag, "_zero"}, {31'd0, zero}, 32'd1);
    chk({tag, "_carry"}, {31'd0, carry}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] rop;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    issue("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 1, 0); wait_idle("add_wrap");
    issue("sub_borrow", 4'd1, 16'h0003, 16'h0005, 1, 0); wait_idle("sub_borrow");
    issue("shl_1", 4'd6, 16'h8001, 16'h0001, 1, 0); wait_idle("shl_1");
    issue("shr_1", 4'd7, 16'h8001, 16'h0001, 1, 0); wait_idle("shr_1");
    issue("shl_0", 4'd6, 16'h1234, 16'h0010, 1, 0); wait_idle("shl_0");
    issue("shr_15", 4'd7, 16'h8000, 16'h000F, 1, 0); wait_idle("shr_15");
    issue("not_a", 4'd5, 16'h0F0F, 16'hFFFF, 1, 0); wait_idle("not_a");
    issue("op_13", 4'd13, 16'hFFFF, 16'hFFFF, 1, 0); wait_idle("op_13");

    // MUL with busy-length measurement
    issue("mul_a", 4'd8, 16'h0123, 16'h0045, 1, 0);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mul_busy_cycles", n, 32'd16);
    wait_idle("mul_a");

    issue("mul_ovf", 4'd8, 16'h1000, 16'h0010, 1, 0); wait_idle("mul_ovf");

    // New start accepted in the same cycle done is high
    issue("mul_ff", 4'd8, 16'h00FF, 16'h0101, 1, 0);
    repeat (16) @(negedge clk);
    issue("add_on_done", 4'd0, 16'h1111, 16'h2222, 1, 0);
    wait_idle("add_on_done");

    // Start during MUL is ignored; operand changes do not disturb it
    issue("mul_ign", 4'd8, 16'h0123, 16'h0045, 1, 0);
    repeat (3) @(negedge clk);
    issue("ign_add", 4'd0, 16'h7777, 16'h0001, 0, 0);
    opa = 16'hFFFF; opb = 16'hFFFF;
    wait_idle("mul_ign");

    // Reset in the middle of a MUL aborts it without a done pulse
    issue("mul_rst", 4'd8, 16'h0003, 16'h0005, 1, 0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_mul_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("xor_after_rst", 4'd4, 16'hAAAA, 16'h5555, 1, 0); wait_idle("xor_after_rst");

    // Back-to-back single-cycle ops with start held high
    issue("b2b_add", 4'd0, 16'h1234, 16'h4321, 1, 1);
    issue("b2b_and", 4'd2, 16'hF0F0, 16'h3C3C, 1, 0);
    wait_idle("b2b");

    for (int k = 0; k < 12; k++) begin
      rop = 4'($urandom_range(0, 15));
      issue("rand", rop, 16'($urandom), 16'($urandom), 1, 0);
      wait_idle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
